// File: rtl/load_store_unit.sv
// RV64 load/store unit in front of a small doubleword-wide data memory.
// Loads read the enclosing doubleword; sub-doubleword stores read-modify-write it.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 64
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [63:0] resp_rdata_o,
    output logic        resp_fault_o,
    output logic [63:0] Mem_Addr_o,
    output logic [63:0] Write_Data_o,
    output logic        MemWrite_o,
    output logic        MemRead_o,
    input  logic [63:0] Read_Data_i
);

    typedef enum logic [1:0] {StIdle, StAccess, StWrite, StResp} state_e;

    state_e      state_q, state_d;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic        fault_q;
    logic [63:0] rd_q;

    logic        accept;
    logic [63:0] req_size;
    logic [64:0] req_end;
    logic        req_fault;

    assign accept   = req_valid_i && (state_q == StIdle);
    assign req_size = 64'd1 << req_funct3_i[1:0];
    // 65-bit sum so addresses near 2^64 cannot wrap back into range
    assign req_end  = {1'b0, req_addr_i} + {1'b0, req_size};

    always_comb begin
        req_fault = 1'b0;
        if ((req_addr_i & (req_size - 64'd1)) != 64'd0) req_fault = 1'b1;
        if (req_end > 65'(MEM_BYTES))                   req_fault = 1'b1;
        if (req_write_i && req_funct3_i[2])             req_fault = 1'b1;
        if (!req_write_i && (req_funct3_i == 3'd7))     req_fault = 1'b1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            write_q  <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 64'd0;
            wdata_q  <= 64'd0;
            fault_q  <= 1'b0;
            rd_q     <= 64'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q  <= req_write_i;
                funct3_q <= req_funct3_i;
                addr_q   <= req_addr_i;
                wdata_q  <= req_wdata_i;
                fault_q  <= req_fault;
            end
            if (state_q == StAccess) rd_q <= Read_Data_i;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (req_valid_i) state_d = req_fault ? StResp : StAccess;
            StAccess: state_d = write_q ? StWrite : StResp;
            StWrite:  state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    logic [5:0]  bit_off;
    logic [63:0] size_mask;
    logic [63:0] merged;
    logic [63:0] field;
    logic [63:0] load_data;

    assign bit_off = {addr_q[2:0], 3'b000};

    always_comb begin
        size_mask = 64'd0;
        case (funct3_q[1:0])
            2'd0:    size_mask = 64'h0000_0000_0000_00FF;
            2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    assign merged = (rd_q & ~(size_mask << bit_off)) | ((wdata_q & size_mask) << bit_off);
    assign field  = rd_q >> bit_off;

    always_comb begin
        load_data = 64'd0;
        case (funct3_q)
            3'd0:    load_data = {{56{field[7]}}, field[7:0]};
            3'd1:    load_data = {{48{field[15]}}, field[15:0]};
            3'd2:    load_data = {{32{field[31]}}, field[31:0]};
            3'd3:    load_data = rd_q;
            3'd4:    load_data = {56'd0, field[7:0]};
            3'd5:    load_data = {48'd0, field[15:0]};
            3'd6:    load_data = {32'd0, field[31:0]};
            default: load_data = 64'd0;
        endcase
    end

    always_comb begin
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_rdata_o = 64'd0;
        resp_fault_o = 1'b0;
        Mem_Addr_o   = 64'd0;
        Write_Data_o = 64'd0;
        MemWrite_o   = 1'b0;
        MemRead_o    = 1'b0;
        unique case (state_q)
            StIdle: req_ready_o = 1'b1;
            StAccess: begin
                MemRead_o  = 1'b1;
                Mem_Addr_o = {addr_q[63:3], 3'b000};
            end
            StWrite: begin
                MemWrite_o   = 1'b1;
                Mem_Addr_o   = {addr_q[63:3], 3'b000};
                Write_Data_o = merged;
            end
            StResp: begin
                resp_valid_o = 1'b1;
                resp_fault_o = fault_q;
                if (!write_q && !fault_q) resp_rdata_o = load_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level reference memory, directed cases then random traffic.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault;
    logic [63:0] resp_rdata;
    logic [63:0] mem_addr, write_data, read_data;
    logic        mem_write, mem_read;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] mem [8];
    logic [7:0]  ref_mem [64];

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(64)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_fault_o (resp_fault),
        .Mem_Addr_o   (mem_addr),
        .Write_Data_o (write_data),
        .MemWrite_o   (mem_write),
        .MemRead_o    (mem_read),
        .Read_Data_i  (read_data)
    );

    assign read_data = mem[mem_addr[5:3]];
    always @(posedge clk) if (mem_write) mem[mem_addr[5:3]] <= write_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_fault(input bit wr, input logic [2:0] f3, input logic [63:0] addr);
        longint unsigned size = 64'd1 << f3[1:0];
        logic [64:0] last = {1'b0, addr} + 65'(size);
        if (addr % size != 0) return 1'b1;
        if (last > 65'd64) return 1'b1;
        if (wr && f3 > 3) return 1'b1;
        if (!wr && f3 == 7) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] addr);
        int size = 1 << f3[1:0];
        logic [63:0] v = 64'd0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[addr[5:0] + 6'(i)];
        if (f3 < 4 && size < 8 && v[8*size-1])
            for (int i = size; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic do_req(input bit wr, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wd);
        bit          exp_fault = ref_fault(wr, f3, addr);
        logic [63:0] exp_data  = (wr || exp_fault) ? 64'd0 : ref_load(f3, addr);
        int          exp_lat   = exp_fault ? 1 : (wr ? 3 : 2);
        logic [7:0]  exp_rmask = exp_fault ? 8'd0 : 8'b0000_0010;
        logic [7:0]  exp_wmask = (exp_fault || !wr) ? 8'd0 : 8'b0000_0100;
        logic [7:0]  rmask = 8'd0, wmask = 8'd0;
        bit          strobe_ok = 1'b1;
        int          waited = 0, lat = 0;
        logic [63:0] got_data = 64'hX;
        logic        got_fault = 1'bX;
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        while (!req_ready && waited < 4) begin
            @(posedge clk); #1;
            waited++;
        end
        check("ready_wait", 64'(waited <= 1), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        req_write = 1'($urandom);
        for (int c = 1; c <= 6; c++) begin
            rmask[c] = mem_read;
            wmask[c] = mem_write;
            if (mem_read && mem_write) strobe_ok = 1'b0;
            if ((mem_read || mem_write) && mem_addr !== {addr[63:3], 3'b000}) strobe_ok = 1'b0;
            if (resp_valid) begin
                lat       = c;
                got_data  = resp_rdata;
                got_fault = resp_fault;
                break;
            end
            @(posedge clk); #1;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("rdata", got_data, exp_data);
        check("fault", 64'(got_fault), 64'(exp_fault));
        check("memread_cycles", 64'(rmask), 64'(exp_rmask));
        check("memwrite_cycles", 64'(wmask), 64'(exp_wmask));
        check("strobe_rules", 64'(strobe_ok), 64'd1);
        if (wr && !exp_fault)
            for (int i = 0; i < (1 << f3[1:0]); i++) ref_mem[addr[5:0] + 6'(i)] = wd[8*i +: 8];
    endtask

    initial begin
        logic [63:0] pre [8];
        pre = '{64'd5, 64'd6, 64'd2, 64'd3, 64'd4, 64'd0, 64'd0, 64'd0};
        for (int d = 0; d < 8; d++) begin
            mem[d] = pre[d];
            for (int b = 0; b < 8; b++) ref_mem[8*d + b] = pre[d][8*b +: 8];
        end
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = 64'd0; req_wdata = 64'd0;
        #12;
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_rdata", resp_rdata, 64'd0);
        check("rst_fault", 64'(resp_fault), 64'd0);
        check("rst_strobes", {62'd0, mem_read, mem_write}, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_write_data", write_data, 64'd0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        do_req(1'b0, 3'd3, 64'd8, 64'd0);                        // LD 8 -> 6
        do_req(1'b1, 3'd0, 64'd9, 64'hAB);                       // SB 9
        do_req(1'b0, 3'd3, 64'd8, 64'd0);
        do_req(1'b0, 3'd3, 64'd0, 64'd0);
        do_req(1'b1, 3'd1, 64'd16, 64'h8001);                    // SH 16
        do_req(1'b0, 3'd1, 64'd16, 64'd0);
        do_req(1'b0, 3'd5, 64'd16, 64'd0);
        do_req(1'b0, 3'd0, 64'd17, 64'd0);
        do_req(1'b0, 3'd2, 64'd2, 64'd0);                        // misaligned LW
        do_req(1'b1, 3'd3, 64'd60, 64'h1);                       // SD 60
        do_req(1'b0, 3'd3, 64'd64, 64'd0);                       // LD 64
        do_req(1'b0, 3'd3, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0);      // wrap attempt
        do_req(1'b1, 3'd4, 64'd0, 64'd0);                        // illegal store size
        do_req(1'b0, 3'd7, 64'd0, 64'd0);                        // illegal load size
        do_req(1'b1, 3'd3, 64'd32, 64'h1122_3344_5566_7788);
        do_req(1'b0, 3'd6, 64'd36, 64'd0);
        do_req(1'b0, 3'd2, 64'd32, 64'd0);
        do_req(1'b0, 3'd2, 64'd36, 64'd0);

        // Store interrupted by reset while in its write cycle
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
        req_addr = 64'd24; req_wdata = 64'hDEAD_BEEF;
        while (!req_ready) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("write_cycle_strobe", 64'(mem_write), 64'd1);
        reset = 1'b1;
        #1;
        check("reset_drops_write", {62'd0, mem_read, mem_write}, 64'd0);
        check("reset_no_resp", 64'(resp_valid), 64'd0);
        @(posedge clk); #1;
        check("reset_no_resp_later", 64'(resp_valid), 64'd0);
        @(negedge clk); reset = 1'b0;
        do_req(1'b0, 3'd3, 64'd24, 64'd0);

        for (int n = 0; n < 300; n++) begin
            bit          wr = 1'($urandom);
            logic [2:0]  f3 = 3'($urandom);
            logic [63:0] a;
            if ($urandom_range(0, 3) != 0) a = 64'($urandom_range(0, 63)) & ~((64'd1 << f3[1:0]) - 64'd1);
            else a = 64'($urandom_range(0, 71));
            if (!wr && f3 == 3'd7 && $urandom_range(0, 1) == 1) f3 = 3'd3;
            if (wr && f3 > 3'd3 && $urandom_range(0, 3) != 0) f3 = {1'b0, f3[1:0]};
            do_req(wr, f3, a, {$urandom, $urandom});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, observed running expected done");
        $fatal(1);
    end

endmodule
